fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of the instruction queue.
- Holds the architectural fetch PC and a direct-mapped one-word-per-line instruction cache.
- Fetches from the memory controller on a cache miss.
- Predicts next PC with a direct-mapped BTB of 2-bit saturating counters. Pushes {inst, PC, predicted next PC, predict bit} into the queue.

Parameters:
ICACHE_LINES, 256, instruction cache lines (power of 2); index PC[9:2], tag PC[31:10] at default
BTB_ENTRIES, 64, BTB entries (power of 2); index PC[7:2], tag PC[31:8] at default
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = all state frozen
roll  in  1  misprediction flush
roll_PC  in  32  redirect target on roll
IQ_full  in  1  registered queue-full flag
IF_flag  out  1  one-cycle push strobe to queue
IF_inst  out  32  fetched instruction
IF_PC  out  32  PC of IF_inst
IF_BTB_PC  out  32  predicted next PC (target or PC+4)
IF_BTB_predict  out  1  predicted-taken bit
Mem_req  out  1  fetch request, held until Mem_done
Mem_addr  out  32  word-aligned request address
Mem_done  in  1  one-cycle response strobe
Mem_inst  in  32  response data, valid with Mem_done
Upd_flag  in  1  branch resolution strobe
Upd_PC  in  32  resolved branch PC
Upd_target  in  32  resolved target
Upd_taken  in  1  resolved direction

Behaviour:
- Reset:
  - PC=RESET_PC, state=IDLE.
  - IF_flag=0, IF_inst/IF_PC/IF_BTB_PC=0, IF_BTB_predict=0.
  - Mem_req=0, Mem_addr=0.
  - All icache and BTB valid bits cleared.
- rdy=0: no state or output changes. Includes cache/BTB writes and the Upd port.
- States:
  - IDLE: lookup icache at PC.
  - WAIT_MEM: request outstanding; latched address in Mem_addr.
- Issue condition, IDLE: !roll && !IQ_full && !IF_flag && icache hit.
  - IF_flag cannot be asserted on consecutive cycles. This guarantees no overflow against the one-cycle-lagged registered IQ_full.
  - On issue, next cycle: IF_flag=1, IF_inst=line data, IF_PC=PC, IF_BTB_PC=pred, IF_BTB_predict=taken; PC<=pred.
  - Otherwise IF_flag<=0.
- Prediction:
  - BTB hit (valid && tag match) with counter>=2: taken=1, pred=stored target.
  - Otherwise taken=0, pred=PC+4, mod 2^32 wrap.
- Miss in IDLE (with !roll): Mem_req<=1, Mem_addr<={PC[31:2],2'b00}, state<=WAIT_MEM; IF_flag<=0.
- WAIT_MEM with Mem_done:
  - Write line at Mem_addr index: valid, tag, data=Mem_inst.
  - Mem_req<=0, state<=IDLE.
  - Issue happens on a later cycle via hit. Hit-to-IF_flag latency 1 cycle; miss-to-IF_flag = memory latency + 2 cycles.
- roll, any state: PC<=roll_PC, IF_flag<=0.
  - In WAIT_MEM the request stays held to completion. The fill is for the old address and is still written. The state returns to IDLE; no instruction from that fill is issued.
  - roll and Mem_done in the same cycle: apply both.
- BTB update on Upd_flag, independent of roll/state:
  - Tag match: counter +1 if taken, -1 if not, saturating 0..3; target<=Upd_target if taken.
  - Tag mismatch or invalid: allocate only if taken, with tag, target, counter=2. Not-taken miss leaves the entry untouched.
  - Update and lookup on the same entry in the same cycle: lookup uses the pre-update value.
- Reset mid-WAIT_MEM: return to IDLE, Mem_req=0. The memory controller is reset in the same cycle.

Test Plan:
- Reset then rdy=1, Mem_done 3 cycles after Mem_req with Mem_inst=32'h00000013 -> Mem_addr=0; line filled; IF_flag pulses with IF_PC=0, IF_BTB_PC=4, IF_BTB_predict=0; next request at Mem_addr=4.
- Icache prefilled for PC 0..0x1C, IQ_full=0 -> IF_flag pulses every other cycle, IF_PC 0,4,8,...; never two consecutive high cycles.
- IQ_full=1 for 6 cycles mid-stream -> no IF_flag while high; stream resumes at the next sequential PC, no skip or duplicate.
- Upd_flag with PC=0x10, target=0x40, taken=1, then fetch reaches 0x10 -> IF_BTB_predict=1, IF_BTB_PC=0x40, next IF_PC=0x40. Two not-taken updates -> predict 0, IF_BTB_PC=0x14.
- roll with roll_PC=0x100 during WAIT_MEM for 0x8 -> Mem_req held until Mem_done; line 0x8 filled; no IF_flag for 0x8; next request address 0x100.
- rdy=0 for 4 cycles with Mem_done and Upd_flag pulsed -> no state, cache or BTB change; outputs stable.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: queue push, instruction memory request and
// branch-resolution update channel.
interface fetch_unit_if;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC;
    logic [31:0] IF_BTB_PC;
    logic        IF_BTB_predict;
    logic        IQ_full;

    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_done;
    logic [31:0] Mem_inst;

    logic        Upd_flag;
    logic [31:0] Upd_PC;
    logic [31:0] Upd_target;
    logic        Upd_taken;

    modport master (
        output IF_flag, IF_inst, IF_PC,
        output IF_BTB_PC, IF_BTB_predict,
        input  IQ_full,
        output Mem_req, Mem_addr,
        input  Mem_done, Mem_inst,
        input  Upd_flag, Upd_PC,
        input  Upd_target, Upd_taken
    );

    modport slave (
        input  IF_flag, IF_inst, IF_PC,
        input  IF_BTB_PC, IF_BTB_predict,
        output IQ_full,
        input  Mem_req, Mem_addr,
        output Mem_done, Mem_inst,
        output Upd_flag, Upd_PC,
        output Upd_target, Upd_taken
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: fetch PC, direct-mapped icache and 2-bit BTB,
// pushing {inst, PC, predicted PC, taken} into the queue.
module fetch_unit #(
    parameter int          ICACHE_LINES = 256,
    parameter int          BTB_ENTRIES  = 64,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         roll,
    input  logic [31:0]  roll_PC,
    fetch_unit_if.master bus
);
    localparam int IW  = $clog2(ICACHE_LINES);
    localparam int ITW = 30 - IW;
    localparam int BW  = $clog2(BTB_ENTRIES);
    localparam int BTW = 30 - BW;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t      state;
    logic [31:0] pc;

    logic [ICACHE_LINES-1:0] ic_valid;
    logic [ITW-1:0]          ic_tag  [ICACHE_LINES];
    logic [31:0]             ic_data [ICACHE_LINES];

    logic [BTB_ENTRIES-1:0]  bt_valid;
    logic [BTW-1:0]          bt_tag    [BTB_ENTRIES];
    logic [31:0]             bt_target [BTB_ENTRIES];
    logic [1:0]              bt_cnt    [BTB_ENTRIES];

    logic [IW-1:0] ic_idx;
    logic [IW-1:0] fill_idx;
    logic [BW-1:0] bt_idx;
    logic [BW-1:0] upd_idx;
    logic          ic_hit;
    logic          bt_taken;
    logic          upd_match;
    logic          fill_en;
    logic          upd_en;
    logic          issue;
    logic [31:0]   pred;
    logic [1:0]    cnt_cur;
    logic [1:0]    cnt_next;
    logic          unused_bits;

    assign ic_idx = pc[IW+1:2];
    assign ic_hit = ic_valid[ic_idx]
                 && ic_tag[ic_idx] == pc[31:IW+2];

    assign bt_idx   = pc[BW+1:2];
    assign bt_taken = bt_valid[bt_idx]
                   && bt_tag[bt_idx] == pc[31:BW+2]
                   && bt_cnt[bt_idx][1];
    assign pred = bt_taken ? bt_target[bt_idx]
                           : pc + 32'd4;

    // Never issue behind a push: IQ_full lags by one cycle.
    assign issue = !roll && !bus.IQ_full
                && !bus.IF_flag && ic_hit;

    assign fill_idx = bus.Mem_addr[IW+1:2];
    assign fill_en  = !rst && rdy && state == WAIT_MEM
                   && bus.Mem_done;

    assign upd_idx   = bus.Upd_PC[BW+1:2];
    assign upd_match = bt_valid[upd_idx]
                    && bt_tag[upd_idx] == bus.Upd_PC[31:BW+2];
    assign upd_en    = !rst && rdy && bus.Upd_flag
                    && (upd_match || bus.Upd_taken);
    assign cnt_cur   = bt_cnt[upd_idx];

    assign unused_bits = ^bus.Upd_PC[1:0];

    always_comb begin
        cnt_next = 2'd2;
        if (upd_match) begin
            if (bus.Upd_taken)
                cnt_next = (cnt_cur == 2'd3) ? 2'd3
                                             : cnt_cur + 2'd1;
            else
                cnt_next = (cnt_cur == 2'd0) ? 2'd0
                                             : cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            ic_tag[fill_idx]  <= bus.Mem_addr[31:IW+2];
            ic_data[fill_idx] <= bus.Mem_inst;
        end
        if (upd_en) begin
            bt_tag[upd_idx] <= bus.Upd_PC[31:BW+2];
            bt_cnt[upd_idx] <= cnt_next;
            if (bus.Upd_taken)
                bt_target[upd_idx] <= bus.Upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            pc                 <= RESET_PC;
            ic_valid           <= '0;
            bt_valid           <= '0;
            bus.IF_flag        <= 1'b0;
            bus.IF_inst        <= 32'h0;
            bus.IF_PC          <= 32'h0;
            bus.IF_BTB_PC      <= 32'h0;
            bus.IF_BTB_predict <= 1'b0;
            bus.Mem_req        <= 1'b0;
            bus.Mem_addr       <= 32'h0;
        end else if (rdy) begin
            if (fill_en)
                ic_valid[fill_idx] <= 1'b1;
            if (upd_en)
                bt_valid[upd_idx] <= 1'b1;
            bus.IF_flag <= 1'b0;
            if (roll)
                pc <= roll_PC;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        bus.IF_flag        <= 1'b1;
                        bus.IF_inst        <= ic_data[ic_idx];
                        bus.IF_PC          <= pc;
                        bus.IF_BTB_PC      <= pred;
                        bus.IF_BTB_predict <= bt_taken;
                        pc                 <= pred;
                    end else if (!roll && !ic_hit) begin
                        bus.Mem_req  <= 1'b1;
                        bus.Mem_addr <= {pc[31:2], 2'b00};
                        state        <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    // A fill racing a roll is still written.
                    if (bus.Mem_done) begin
                        bus.Mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a
// transaction-level model of the fetch stream.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        roll;
    logic [31:0] roll_PC;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .roll    (roll),
        .roll_PC (roll_PC),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [31:0] tgt;
        int          cnt;
    } btb_e;

    logic [31:0] mpc;
    logic [31:0] ic_addr [int];
    btb_e        btb [64];

    int          cyc = 0;
    int          req_step = 0;
    int          push_step = 0;
    int          pushes = 0;
    int          saw_taken = 0;
    bit          pushed = 0;
    logic [31:0] last_pc = 0;
    bit          mem_active = 0;
    int          mem_cnt = 0;
    int          lat = 3;

    task automatic chk(string tag, logic [31:0] o,
                       logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, o, e);
        end
    endtask

    task automatic chkw(string tag, logic [130:0] o,
                        logic [130:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, o, e);
        end
    endtask

    function automatic logic [130:0] outs();
        return {bus.IF_flag, bus.IF_inst, bus.IF_PC,
                bus.IF_BTB_PC, bus.IF_BTB_predict,
                bus.Mem_req, bus.Mem_addr};
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'h13 + {a[23:0], 8'h00};
    endfunction

    function automatic int ic_i(logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    function automatic int bt_i(logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic bit m_cached(logic [31:0] a);
        return ic_addr.exists(ic_i(a)) && ic_addr[ic_i(a)] == a;
    endfunction

    function automatic bit m_taken(logic [31:0] p);
        int i = bt_i(p);
        return btb[i].valid && btb[i].pc[31:2] == p[31:2]
            && btb[i].cnt >= 2;
    endfunction

    function automatic logic [31:0] m_pred(logic [31:0] p);
        return m_taken(p) ? btb[bt_i(p)].tgt : p + 32'd4;
    endfunction

    task automatic m_update(logic [31:0] p, logic [31:0] t,
                            logic tk);
        int i = bt_i(p);
        if (btb[i].valid && btb[i].pc[31:2] == p[31:2]) begin
            if (tk) begin
                btb[i].cnt = (btb[i].cnt < 3) ? btb[i].cnt + 1 : 3;
                btb[i].tgt = t;
            end else begin
                btb[i].cnt = (btb[i].cnt > 0) ? btb[i].cnt - 1 : 0;
            end
        end else if (tk) begin
            btb[i] = '{1'b1, p, t, 2};
        end
    endtask

    task automatic step();
        logic        c_rst, c_rdy, c_roll, c_iqf, c_done;
        logic        c_upd, c_tk, p_flag, p_req;
        logic [31:0] c_rpc, c_upc, c_utg, p_addr;
        logic [130:0] prev;
        bit          consumed;
        c_rst = rst;  c_rdy = rdy;  c_roll = roll;
        c_rpc = roll_PC;  c_iqf = bus.IQ_full;
        c_done = bus.Mem_done;  c_upd = bus.Upd_flag;
        c_upc = bus.Upd_PC;  c_utg = bus.Upd_target;
        c_tk = bus.Upd_taken;
        p_flag = bus.IF_flag;  p_req = bus.Mem_req;
        p_addr = bus.Mem_addr;  prev = outs();
        consumed = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        pushed = 0;
        if (c_rst) begin
            mpc = 32'h0;
            ic_addr.delete();
            for (int i = 0; i < 64; i++) btb[i].valid = 0;
            mem_active = 0;
        end else if (!c_rdy) begin
            chkw("freeze", outs(), prev);
        end else begin
            consumed = p_req && c_done;
            if (bus.IF_flag) begin
                chk("if_consec", 32'(p_flag), 0);
                chk("if_gate", 32'({c_roll, c_iqf}), 0);
                chk("IF_PC", bus.IF_PC, mpc);
                chk("IF_inst", bus.IF_inst, mem_word(mpc));
                chk("IF_predict", 32'(bus.IF_BTB_predict),
                    32'(m_taken(mpc)));
                chk("IF_BTB_PC", bus.IF_BTB_PC, m_pred(mpc));
                if (m_taken(mpc)) saw_taken++;
                mpc = m_pred(mpc);
                last_pc = bus.IF_PC;
                pushed = 1;
                pushes++;
                push_step = cyc;
            end
            if (c_roll) mpc = c_rpc;
            if (p_req && !consumed) begin
                chk("req_hold", {bus.Mem_req, bus.Mem_addr[30:0]},
                    {1'b1, p_addr[30:0]});
            end else if (p_req) begin
                chk("req_drop", 32'(bus.Mem_req), 0);
            end else if (bus.Mem_req) begin
                chk("miss_addr", bus.Mem_addr, mpc);
                chk("miss_real", 32'(m_cached(mpc)), 0);
                req_step = cyc;
            end
            if (consumed) ic_addr[ic_i(p_addr)] = p_addr;
            if (c_upd) m_update(c_upc, c_utg, c_tk);
        end
        if (c_rst || consumed) mem_active = 0;
        if (bus.Mem_req && !mem_active) begin
            mem_active = 1;
            mem_cnt = lat;
        end
        if (mem_active && mem_cnt > 0) mem_cnt--;
        bus.Mem_done = mem_active && mem_cnt == 0;
        bus.Mem_inst = mem_word(bus.Mem_addr);
    endtask

    task automatic run_pushes(int n, int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            step();
            t++;
            if (pushed) got++;
        end
        chk("push_budget", got, n);
    endtask

    task automatic do_roll(logic [31:0] a);
        roll = 1'b1;
        roll_PC = a;
        step();
        roll = 1'b0;
    endtask

    task automatic upd(logic [31:0] p, logic [31:0] t,
                       logic tk);
        bus.Upd_flag = 1'b1;
        bus.Upd_PC = p;
        bus.Upd_target = t;
        bus.Upd_taken = tk;
        step();
        bus.Upd_flag = 1'b0;
    endtask

    initial begin
        int got, t, lastp, p0;
        rst = 1'b1;  rdy = 1'b1;  roll = 1'b0;  roll_PC = 0;
        bus.IQ_full = 0;  bus.Mem_done = 0;  bus.Mem_inst = 0;
        bus.Upd_flag = 0;  bus.Upd_PC = 0;
        bus.Upd_target = 0;  bus.Upd_taken = 0;
        repeat (3) step();
        chk("rst_IF_flag", 32'(bus.IF_flag), 0);
        chk("rst_IF_inst", bus.IF_inst, 0);
        chk("rst_IF_PC", bus.IF_PC, 0);
        chk("rst_IF_BTB_PC", bus.IF_BTB_PC, 0);
        chk("rst_predict", 32'(bus.IF_BTB_predict), 0);
        chk("rst_Mem_req", 32'(bus.Mem_req), 0);
        chk("rst_Mem_addr", bus.Mem_addr, 0);
        rst = 1'b0;

        run_pushes(1, 20);
        chk("miss_latency", push_step - req_step, 4);
        chk("first_pc", last_pc, 0);
        run_pushes(1, 20);

        t = 0;
        while (!bus.Mem_req && t < 20) begin step(); t++; end
        chk("req8_addr", bus.Mem_addr, 32'h8);
        do_roll(32'h100);
        chk("roll_hold", 32'(bus.Mem_req), 1);
        run_pushes(1, 40);
        chk("post_roll_pc", last_pc, 32'h100);

        do_roll(0);
        run_pushes(8, 200);

        do_roll(0);
        got = 0;  t = 0;  lastp = 0;
        while (got < 8 && t < 40) begin
            step();
            t++;
            if (pushed) begin
                if (got > 0) chk("hit_gap", cyc - lastp, 2);
                lastp = cyc;
                got++;
            end
        end
        chk("hit_count", got, 8);

        do_roll(0);
        run_pushes(3, 20);
        bus.IQ_full = 1'b1;
        got = 0;
        repeat (6) begin step(); if (pushed) got++; end
        chk("iqfull_quiet", got, 0);
        bus.IQ_full = 1'b0;
        run_pushes(4, 20);
        chk("iqfull_resume", last_pc, 32'h18);

        upd(32'h10, 32'h40, 1'b1);
        do_roll(0);
        saw_taken = 0;
        run_pushes(6, 100);
        chk("btb_taken", saw_taken, 1);
        chk("btb_target", last_pc, 32'h40);
        upd(32'h10, 32'h0, 1'b0);
        upd(32'h10, 32'h0, 1'b0);
        do_roll(0);
        saw_taken = 0;
        run_pushes(6, 100);
        chk("btb_untaken", saw_taken, 0);
        chk("btb_fallthru", last_pc, 32'h14);

        do_roll(32'h200);
        t = 0;
        while (!bus.Mem_req && t < 10) begin step(); t++; end
        chk("freeze_req", 32'(bus.Mem_req), 1);
        rdy = 1'b0;
        bus.Upd_flag = 1'b1;  bus.Upd_PC = 0;
        bus.Upd_target = 32'h70;  bus.Upd_taken = 1'b1;
        repeat (4) begin bus.Mem_done = 1'b1; step(); end
        rdy = 1'b1;
        bus.Upd_flag = 1'b0;
        run_pushes(1, 40);
        chk("freeze_resume", last_pc, 32'h200);
        do_roll(0);
        run_pushes(2, 50);

        p0 = pushes;
        repeat (800) begin
            lat = $urandom_range(1, 4);
            rdy = ($urandom_range(0, 9) != 0);
            bus.IQ_full = ($urandom_range(0, 3) == 0);
            roll = ($urandom_range(0, 24) == 0);
            roll_PC = 32'($urandom_range(0, 31)) << 2;
            bus.Upd_flag = ($urandom_range(0, 4) == 0);
            bus.Upd_PC = 32'($urandom_range(0, 95)) << 2;
            bus.Upd_target = 32'($urandom_range(0, 95)) << 2;
            bus.Upd_taken = 1'($urandom_range(0, 1));
            step();
        end
        chk("rand_progress", 32'(pushes > p0 + 20), 1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
